vout_ctrl: RTL

//   Output-side read controller for the scale-down frame path; the reader counterpart of the input write controller.
//   On a frame_start pulse it raster-scans vout_xres x vout_yres, issuing (rd_x, rd_y) read requests to the frame/line memory.

---
 rtl/vout_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vout_ctrl.sv
// ---------------------------------------------------------------------------
// vout_ctrl
// Output-side read controller for the scale-down frame path. On an accepted
// frame_start it raster-scans vout_xres x vout_yres, issuing (rd_x, rd_y)
// reads to the frame/line memory. Read data comes back RD_LAT cycles later,
// is buffered in a small show-ahead FIFO and leaves as a valid/ready stream
// tagged with sof/eol/eof. Reads are only issued while the in-flight reads
// plus the FIFO contents leave room, so backpressure never drops data.
//
// Ports
//   vout_clk     in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   frame_start  in   1-cycle pulse, a full frame is ready to read
//   vout_xres    in   [15:0] frame width, sampled on an accepted frame_start
//   vout_yres    in   [15:0] frame height, sampled on an accepted frame_start
//   rd_en        out  read request this cycle
//   rd_x, rd_y   out  [15:0] read coordinates, valid while rd_en=1
//   rd_dat       in   [DW-1:0] read data, valid RD_LAT cycles after rd_en
//   vout_valid   out  output beat valid
//   vout_ready   in   downstream accepts the beat
//   vout_dat     out  [DW-1:0] output pixel (FIFO head)
//   vout_sof     out  first pixel of the frame
//   vout_eol     out  last pixel of a line
//   vout_eof     out  last pixel of the frame
//   busy         out  controller is not idle
// ---------------------------------------------------------------------------
module vout_ctrl #(
  parameter int DW         = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          vout_clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [15:0]   vout_xres,
  input  logic [15:0]   vout_yres,
  output logic          rd_en,
  output logic [15:0]   rd_x,
  output logic [15:0]   rd_y,
  input  logic [DW-1:0] rd_dat,
  output logic          vout_valid,
  input  logic          vout_ready,
  output logic [DW-1:0] vout_dat,
  output logic          vout_sof,
  output logic          vout_eol,
  output logic          vout_eof,
  output logic          busy
);

  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  logic [1:0]    state_q, state_d;
  logic [15:0]   xres_q, xres_d, yres_q, yres_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [OW-1:0] occ_q, occ_d;
  tag_t          pipe_q [RD_LAT];

  logic [DW-1:0] fdat_q [FIFO_DEPTH];
  logic [2:0]    ftag_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] fcnt_q, fcnt_d;

  logic x_last, y_last, start_ok, credit_ok, issue, pop, fifo_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign x_last    = (x_q == xres_q - 16'd1);
  assign y_last    = (y_q == yres_q - 16'd1);
  assign start_ok  = (state_q == S_IDLE) && frame_start &&
                     (vout_xres != 16'd0) && (vout_yres != 16'd0);
  // occ counts every pixel already promised a FIFO slot (in flight + stored).
  assign credit_ok = (occ_q < OW'(FIFO_DEPTH));
  assign issue     = (state_q == S_RUN) && credit_ok;
  assign pop       = vout_valid && vout_ready;
  assign fifo_wr   = pipe_q[RD_LAT-1].valid;
  assign occ_d     = occ_q + OW'(issue) - OW'(pop);
  assign fcnt_d    = fcnt_q + OW'(fifo_wr) - OW'(pop);

  // NOTE: every signal driven here gets a default first, otherwise the
  // incomplete case/if paths would infer latches.
  always_comb begin
    state_d = state_q;
    xres_d  = xres_q;
    yres_d  = yres_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          xres_d  = vout_xres;
          yres_d  = vout_yres;
          x_d     = 16'd0;
          y_d     = 16'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (x_last) begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
            if (y_last) state_d = S_DRAIN;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        // The eof beat is the last one issued, so an empty pipe+FIFO after
        // this cycle's pop means it has been accepted.
        if (occ_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      xres_q  <= '0;
      yres_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      xres_q  <= xres_d;
      yres_q  <= yres_d;
      x_q     <= x_d;
      y_q     <= y_d;
      occ_q   <= occ_d;
    end
  end

  // Tags ride alongside the memory latency so they meet rd_dat at the FIFO.
  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: issue,
                     sof:   (x_q == 16'd0) && (y_q == 16'd0),
                     eol:   x_last,
                     eof:   x_last && y_last};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      fcnt_q <= fcnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count/pointers define which entries
  // are live, and the outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge vout_clk) begin
    if (fifo_wr) begin
      fdat_q[wr_ptr_q] <= rd_dat;
      ftag_q[wr_ptr_q] <= {pipe_q[RD_LAT-1].sof, pipe_q[RD_LAT-1].eol,
                           pipe_q[RD_LAT-1].eof};
    end
  end

  assign rd_en      = issue;
  assign rd_x       = x_q;
  assign rd_y       = y_q;
  assign busy       = (state_q != S_IDLE);
  assign vout_valid = (fcnt_q != '0);
  assign vout_dat   = vout_valid ? fdat_q[rd_ptr_q] : '0;
  assign vout_sof   = vout_valid && ftag_q[rd_ptr_q][2];
  assign vout_eol   = vout_valid && ftag_q[rd_ptr_q][1];
  assign vout_eof   = vout_valid && ftag_q[rd_ptr_q][0];

endmodule
